key_round_robin_dispatch: RTL and testbench
===========================================

Name: key_round_robin_dispatch

Overview:
- Routes a single debounced key pulse (`key_flag`) to one of CH_NUM output channels in round-robin order.
- Each accepted press emits a one-cycle pulse on the selected channel after a programmable hold delay.
- Sits between the key debouncer and the power/mode control blocks.
- Generalises the two-channel alternate-press power key block with:
  - N channels and a parametrised delay
  - a direction control and a pointer preload
  - press-drop reporting

Parameters:
- CH_NUM, 2, number of output channels; legal 2..16.
- HOLD_CYCLES, 50000, clocks from key acceptance to channel pulse; legal 1..2^28.
- Derived (localparam, not overridable):
  - CW = max(1, clog2(CH_NUM))
  - TW = clog2(HOLD_CYCLES+1)

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_flag  input  1  one-cycle press pulse from the debouncer.
- dir  input  1  pointer advance direction: 1 = increment, 0 = decrement (both wrap).
- ptr_load  input  1  load the channel pointer from ptr_val.
- ptr_val  input  CW  new pointer value; ignored if >= CH_NUM.
- key_pulse  output  CH_NUM  one-hot one-cycle pulse on the dispatched channel.
- busy  output  1  high while a hold delay is running.
- cur_ch  output  CW  channel the next accepted press will target.
- drop_pulse  output  1  one-cycle pulse when a press is discarded.

Behaviour:
- Reset values: ptr=0, state=IDLE, timer=0, key_pulse=0, busy=0, cur_ch=0, drop_pulse=0, pending=0. `rst` asserted mid-HOLD aborts silently; no pulse is ever emitted for the aborted press.
- States:
  - IDLE: waiting for a press.
  - HOLD: timer running.
  - FIRE: key_pulse asserted.
- Acceptance: key_flag=1 in IDLE or FIRE is accepted.
  - On the accepting edge: tgt<=ptr, ptr advances per dir with wrap, timer<=0, state<=HOLD.
  - Increment wrap: CH_NUM-1 -> 0.
  - Decrement wrap: 0 -> CH_NUM-1.
- HOLD:
  - timer increments each clock.
  - On the edge where timer==HOLD_CYCLES-1, state<=FIRE and key_pulse[tgt]<=1.
  - HOLD_CYCLES=1 goes directly to FIRE on the edge after acceptance.
- FIRE: lasts exactly one cycle. Next state is HOLD if a new press is accepted that cycle, else IDLE.
- Latency: key_pulse is high in the cycle that begins exactly HOLD_CYCLES+1 rising edges after the edge that sampled key_flag; duration 1 cycle; exactly one bit set.
- busy: equals (state==HOLD), registered with the state.
- key_flag in HOLD: discarded; drop_pulse=1 on the next cycle; ptr unchanged.
- ptr_load:
  - Takes effect on the next edge in any state.
  - If it coincides with an accepted press, the press uses the old ptr and ptr becomes ptr_val (the load wins over the advance).
  - An out-of-range ptr_val leaves ptr unchanged; the advance still applies.
- cur_ch: equals the registered ptr.
- Change timing: dir is sampled only on the accepting edge; changes at any other time have no effect.

Optional Feature:
- Macro: KEY_RR_DISPATCH_PENDING_EN.
- Defined:
  - One pending-press register is added.
  - The first key_flag during HOLD sets pending (no drop_pulse); further presses during HOLD with pending=1 produce drop_pulse.
  - In FIRE with pending=1 and no new key_flag, the pending press is accepted as if key_flag were present, and pending clears.
  - If key_flag and pending coincide in FIRE, one press is accepted, pending stays set, and the extra press is not dropped.
  - pending is cleared by `rst`.
- Undefined: no pending register; every press during HOLD is dropped as described in Behaviour.

Test Plan:
- CH_NUM=4, HOLD_CYCLES=10, dir=1; key_flag at cycle 0 -> key_pulse=4'b0001 in cycle 11 only; busy cycles 1-10; cur_ch 0->1 at cycle 1.
- Four presses spaced 20 cycles, dir=1, then a fifth -> pulses on channels 0,1,2,3,0 (wrap); dir=0 from ptr=0 -> next press targets 0, cur_ch becomes 3.
- Press at cycle 0, second press at cycle 5 (HOLD=10) -> drop_pulse at cycle 6, single pulse on ch0 at cycle 11, cur_ch=1; with KEY_RR_DISPATCH_PENDING_EN -> no drop, ch0 pulse at cycle 11, ch1 pulse at cycle 22.
- Press arriving in the FIRE cycle (cycle 11) -> accepted, busy from cycle 12, next channel pulse at cycle 22, no drop.
- ptr_load=1, ptr_val=2 coincident with accepted press at ptr=0 -> pulse on ch0, cur_ch=2 afterward; ptr_val=7 with CH_NUM=4 -> ptr unchanged.
- rst asserted at cycle 5 of HOLD, released at cycle 8 -> key_pulse never asserts, busy=0, cur_ch=0, all outputs at reset values asynchronously.

Source files
------------

// File: rtl/key_round_robin_dispatch.sv
// key_round_robin_dispatch
// Routes debounced key presses to CH_NUM output channels in round-robin order.
// Each accepted press produces a one-cycle one-hot pulse on its target channel
// HOLD_CYCLES clocks after acceptance. Presses arriving while a hold delay is
// running are dropped and reported on drop_pulse.
// Optional build macro KEY_RR_DISPATCH_PENDING_EN adds a one-deep pending-press
// register so that the first press during a hold is queued instead of dropped.
//
// Handshake: key_flag is a single-cycle strobe with no back-pressure; the block
// either accepts it (IDLE/FIRE), queues it (pending build) or drops it, and every
// output (key_pulse, drop_pulse, busy) is a registered level/strobe.

module key_round_robin_dispatch #(
    parameter int CH_NUM      = 2,
    parameter int HOLD_CYCLES = 50000,
    localparam int CW         = (CH_NUM <= 2) ? 1 : $clog2(CH_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_flag,
    input  logic              dir,
    input  logic              ptr_load,
    input  logic [CW-1:0]     ptr_val,
    output logic [CH_NUM-1:0] key_pulse,
    output logic              busy,
    output logic [CW-1:0]     cur_ch,
    output logic              drop_pulse
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);

    localparam logic [TW-1:0]     TIMER_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]     PTR_LAST   = CW'(CH_NUM - 1);
    localparam logic [CW:0]       CH_LIMIT   = (CW + 1)'(CH_NUM);
    localparam logic [CH_NUM-1:0] ONE_HOT0   = {{(CH_NUM - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FIRE = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [CW-1:0] ptr;
    logic [CW-1:0] tgt;
    logic [CW-1:0] ptr_adv;
    logic          ptr_val_ok;
    logic          accept;

`ifdef KEY_RR_DISPATCH_PENDING_EN
    logic          pending;
`endif

    assign cur_ch     = ptr;
    assign ptr_val_ok = ({1'b0, ptr_val} < CH_LIMIT);

    // A press is taken whenever no hold delay is running; in the pending build a
    // queued press is also taken in the FIRE cycle.
`ifdef KEY_RR_DISPATCH_PENDING_EN
    assign accept = (key_flag && (state != HOLD)) || ((state == FIRE) && pending);
`else
    assign accept = key_flag && (state != HOLD);
`endif

    // Next pointer value after an accepted press, wrapping in either direction.
    always_comb begin
        ptr_adv = ptr;
        if (dir) begin
            ptr_adv = (ptr == PTR_LAST) ? '0 : ptr + CW'(1);
        end else begin
            ptr_adv = (ptr == '0) ? PTR_LAST : ptr - CW'(1);
        end
    end

    // Dispatch FSM: pointer, hold timer, target latch and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            ptr        <= '0;
            tgt        <= '0;
            key_pulse  <= '0;
            busy       <= 1'b0;
            drop_pulse <= 1'b0;
`ifdef KEY_RR_DISPATCH_PENDING_EN
            pending    <= 1'b0;
`endif
        end else begin
            key_pulse  <= '0;
            drop_pulse <= 1'b0;

            // A valid load overrides the advance; the press still uses the old ptr.
            if (ptr_load && ptr_val_ok) begin
                ptr <= ptr_val;
            end else if (accept) begin
                ptr <= ptr_adv;
            end

            if (accept) begin
                tgt   <= ptr;
                timer <= '0;
                state <= HOLD;
                busy  <= 1'b1;
            end

            case (state)
                HOLD: begin
                    if (timer == TIMER_LAST) begin
                        state     <= FIRE;
                        busy      <= 1'b0;
                        key_pulse <= ONE_HOT0 << tgt;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                    if (key_flag) begin
`ifdef KEY_RR_DISPATCH_PENDING_EN
                        if (pending) begin
                            drop_pulse <= 1'b1;
                        end else begin
                            pending <= 1'b1;
                        end
`else
                        drop_pulse <= 1'b1;
`endif
                    end
                end
                FIRE: begin
                    if (!accept) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`ifdef KEY_RR_DISPATCH_PENDING_EN
                    // A fresh press in the same cycle is taken first; the queued
                    // one then stays pending for the next FIRE.
                    if (pending && !key_flag) begin
                        pending <= 1'b0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_round_robin_dispatch.sv
// Bench for key_round_robin_dispatch: directed press sequences followed by
// random stimulus, checked by a cycle-based reference model and a scoreboard.

module tb_key_round_robin_dispatch;

    localparam int CH = 5;
    localparam int H  = 10;
    localparam int CW = 3;

    typedef struct {
        int          c;
        logic [CH-1:0] v;
    } pev_t;

    typedef struct {
        logic          busy;
        logic [CW-1:0] ch;
    } st_t;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_flag = 1'b0;
    logic          dir = 1'b1;
    logic          ptr_load = 1'b0;
    logic [CW-1:0] ptr_val = '0;
    logic [CH-1:0] key_pulse;
    logic          busy;
    logic [CW-1:0] cur_ch;
    logic          drop_pulse;

    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_round_robin_dispatch #(
        .CH_NUM      (CH),
        .HOLD_CYCLES (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_flag   (key_flag),
        .dir        (dir),
        .ptr_load   (ptr_load),
        .ptr_val    (ptr_val),
        .key_pulse  (key_pulse),
        .busy       (busy),
        .cur_ch     (cur_ch),
        .drop_pulse (drop_pulse)
    );

    // ---------------- scoreboard state ----------------
    pev_t exp_q[$];
    int   drop_q[$];
    st_t  st_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycle number of the last accepted press, pointer, pending.
    int acc_c  = -1000;
    int ptr_m  = 0;
    bit pend_m = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        drop_q.delete();
        st_q.delete();
        acc_c  = -1000;
        ptr_m  = 0;
        pend_m = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of inputs and records what the outputs must do.
    task automatic step(input logic kf, input logic d, input logic ld, input logic [CW-1:0] lv);
        int   c;
        bit   bsy;
        bit   fire;
        bit   acc;
        pev_t pe;
        st_t  st;
        @(posedge clk);
        #1;
        c        = cyc;
        key_flag = kf;
        dir      = d;
        ptr_load = ld;
        ptr_val  = lv;

        // Busy for the H cycles after the accepting cycle; pulse in the next one.
        bsy  = (c >= acc_c + 1) && (c <= acc_c + H);
        fire = (c == acc_c + H + 1);
        st.busy = bsy;
        st.ch   = CW'(ptr_m);
        st_q.push_back(st);

        acc = 1'b0;
        if (kf && !bsy) begin
            acc = 1'b1;
        end else if (kf && bsy) begin
`ifdef KEY_RR_DISPATCH_PENDING_EN
            if (pend_m) drop_q.push_back(c + 1);
            else        pend_m = 1'b1;
`else
            drop_q.push_back(c + 1);
`endif
        end
`ifdef KEY_RR_DISPATCH_PENDING_EN
        if (!kf && fire && pend_m) begin
            acc    = 1'b1;
            pend_m = 1'b0;
        end
`else
        if (fire && 1'b0) acc = 1'b1;
`endif

        if (acc) begin
            pe.c = c + H + 1;
            pe.v = '0;
            pe.v[ptr_m] = 1'b1;
            exp_q.push_back(pe);
            acc_c = c;
        end

        if (ld && (int'(lv) < CH)) ptr_m = int'(lv);
        else if (acc)              ptr_m = d ? (ptr_m + 1) % CH : (ptr_m + CH - 1) % CH;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        pev_t e;
        st_t  s;
        if (!rst) begin
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                check("busy", busy, s.busy);
                check("cur_ch", cur_ch, s.ch);
            end
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                e = exp_q.pop_front();
                check("key_pulse", key_pulse, e.v);
            end else begin
                check("key_pulse_quiet", key_pulse, 0);
            end
            if (drop_q.size() > 0 && drop_q[0] == cyc) begin
                void'(drop_q.pop_front());
                check("drop_pulse", drop_pulse, 1);
            end else begin
                check("drop_pulse_quiet", drop_pulse, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state, seen while rst is held.
        #1;
        check("rst_key_pulse", key_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_ch", cur_ch, 0);
        check("rst_drop", drop_pulse, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single press, then five presses spaced 20 cycles (wraps 4 -> 0).
        step(1'b1, 1'b1, 1'b0, '0);
        idle(25);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            idle(19);
        end

        // Decrement from ptr=0: targets 0, pointer wraps to CH-1.
        step(1'b0, 1'b1, 1'b1, 3'd0);
        step(1'b1, 1'b0, 1'b0, '0);
        idle(20);

        // Second press five cycles into a hold.
        step(1'b1, 1'b1, 1'b0, '0);
        idle(4);
        step(1'b1, 1'b1, 1'b0, '0);
        idle(30);

        // Press exactly in the FIRE cycle.
        step(1'b1, 1'b1, 1'b0, '0);
        idle(H);
        step(1'b1, 1'b1, 1'b0, '0);
        idle(25);

        // Load coincident with a press, then out-of-range loads.
        step(1'b0, 1'b1, 1'b1, 3'd0);
        step(1'b1, 1'b1, 1'b1, 3'd2);
        idle(15);
        step(1'b1, 1'b1, 1'b1, 3'd7);
        idle(15);
        step(1'b0, 1'b1, 1'b1, 3'd6);
        idle(3);

        // Asynchronous reset in the middle of a hold aborts the press.
        step(1'b1, 1'b1, 1'b0, '0);
        idle(5);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_key_pulse", key_pulse, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cur_ch", cur_ch, 0);
        check("mid_rst_drop", drop_pulse, 0);
        repeat (3) @(posedge clk);
        #1;
        check("held_rst_key_pulse", key_pulse, 0);
        check("held_rst_busy", busy, 0);
        rst = 1'b0;
        idle(25);

        // Random phase.
        for (int i = 0; i < 900; i++) begin
            step(($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 11) == 0),
                 CW'($urandom_range(0, 7)));
        end

        idle(H + 5);
        check("exp_q_drained", exp_q.size(), 0);
        check("drop_q_drained", drop_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
